// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch stage's redirect, instruction-memory and decode-side
// signals.
//   master : the fetch unit. It drives mem_req/mem_addr toward memory and
//            out_*/halted/fq_count toward decode.
//   slave  : the environment, i.e. EX (redirect), memory (gnt/rvalid/rdata)
//            and decode (out_ready).
interface if_fetch_unit_if #(
    parameter int INST_L   = 32,
    parameter int PC_L     = 32,
    parameter int MADDR_L  = 32,
    parameter int FQ_DEPTH = 4
) ();
    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic                redirect_valid;
    logic [PC_L-1:0]     redirect_pc;
    logic                mem_req;
    logic [MADDR_L-1:0]  mem_addr;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [INST_L-1:0]   mem_rdata;
    logic                out_valid;
    logic                out_ready;
    logic [INST_L-1:0]   out_inst;
    logic [PC_L-1:0]     out_pc;
    logic                halted;
    logic [CNT_W-1:0]    fq_count;

    modport master (
        input  redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_inst, out_pc, halted, fq_count
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_inst, out_pc, halted, fq_count
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage for the MIPS pipeline.
// The unit keeps at most one word read outstanding to instruction memory over
// req/gnt/rvalid. Fetched {pc, inst} pairs go into an FQ_DEPTH-entry queue, and
// decode drains that queue over valid/ready. A redirect from EX flushes the
// queue, retargets the PC and marks any in-flight read as stale. When
// HALT_ON_ZERO is set, an all-zero fetched word halts fetch until the next
// redirect.
// Ports:
//   clk, rst : clock; asynchronous active-high reset
//   bus      : if_fetch_unit_if.master
//              redirect_valid/redirect_pc : redirect from EX
//              mem_req/mem_addr           : request to memory
//              mem_gnt/mem_rvalid/mem_rdata : response from memory
//              out_valid/out_ready/out_inst/out_pc : queue head to decode
//              halted, fq_count           : status
module if_fetch_unit #(
    parameter int              INST_L       = 32,
    parameter int              PC_L         = 32,
    parameter int              MADDR_L      = 32,
    parameter logic [PC_L-1:0] PC_ENTRY     = 32'h0000_0000,
    parameter int              FQ_DEPTH     = 4,
    parameter int              BYTE_SWAP    = 0,
    parameter int              HALT_ON_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PC_L-1:0]  PC_STEP = {{(PC_L-3){1'b0}}, 3'b100};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Reverses the byte order of a memory word. Used for opposite-endian memories.
    function automatic logic [INST_L-1:0] byte_swap(input logic [INST_L-1:0] w);
        logic [INST_L-1:0] r;
        r = {INST_L{1'b0}};
        for (int i = 0; i < INST_L / 8; i++) begin
            r[i*8 +: 8] = w[INST_L-8-i*8 +: 8];
        end
        return r;
    endfunction

    state_t              state_r, state_s;
    logic [PC_L-1:0]     pc_r, pc_s;
    logic [PC_L-1:0]     req_pc_r, req_pc_s;
    logic                stale_r, stale_s;
    logic                halted_r, halted_s;
    logic                mem_req_r, mem_req_s;
    logic [MADDR_L-1:0]  mem_addr_r;
    logic                out_valid_r;
    logic [CNT_W-1:0]    count_r, count_s;
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [PC_L-1:0]     fq_pc_r   [FQ_DEPTH];
    logic [INST_L-1:0]   fq_inst_r [FQ_DEPTH];

    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic                flush_s;
    logic [INST_L-1:0]   word_s;
    logic                unused_s;

    // The low two bits of the redirect target are forced to zero (word alignment), so they are not used.
    assign unused_s = ^bus.redirect_pc[1:0];

    assign flush_s  = bus.redirect_valid;
    assign accept_s = (state_r == ST_REQ) && mem_req_r && bus.mem_gnt;
    assign word_s   = (BYTE_SWAP != 0) ? byte_swap(bus.mem_rdata) : bus.mem_rdata;
    // A pop that coincides with a flush is cancelled, because the entry is gone anyway.
    assign pop_s    = out_valid_r && bus.out_ready && !flush_s;

    // Next-state logic, PC update, stale tracking and enqueue decision.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        req_pc_s = req_pc_r;
        stale_s  = stale_r;
        halted_s = halted_r;
        push_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_REQ;
            end
            ST_REQ: begin
                if (accept_s) begin
                    req_pc_s = pc_r;
                    state_s  = ST_WAIT;
                end else begin
                    state_s  = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (!bus.mem_rvalid) begin
                    state_s = ST_WAIT;
                end else if (stale_r) begin
                    stale_s = 1'b0;
                    state_s = ST_REQ;
                end else if ((HALT_ON_ZERO != 0) && (word_s == {INST_L{1'b0}})) begin
                    halted_s = 1'b1;
                    state_s  = ST_HALT;
                end else begin
                    push_s  = 1'b1;
                    pc_s    = req_pc_r + PC_STEP;
                    state_s = ST_REQ;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A redirect overrides everything decided above for this cycle.
        if (bus.redirect_valid) begin
            pc_s     = {bus.redirect_pc[PC_L-1:2], 2'b00};
            halted_s = 1'b0;
            push_s   = 1'b0;
            case (state_r)
                ST_WAIT: begin
                    // A word that arrives together with the redirect is simply dropped.
                    // Otherwise the word still in flight must be discarded when it arrives.
                    if (bus.mem_rvalid) begin
                        stale_s = 1'b0;
                        state_s = ST_REQ;
                    end else begin
                        stale_s = 1'b1;
                        state_s = ST_WAIT;
                    end
                end
                ST_REQ: begin
                    if (accept_s) begin
                        stale_s = 1'b1;
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                default: begin
                    state_s = ST_REQ;
                end
            endcase
        end else begin
            stale_s = stale_s;
        end
    end

    // Queue occupancy after this cycle's push, pop or flush.
    always_comb begin
        count_s = count_r;
        if (flush_s) begin
            count_s = {CNT_W{1'b0}};
        end else if (push_s && !pop_s) begin
            count_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_s = count_r - CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Issue gate. A request is raised only in REQ and only when the queue still has room.
    always_comb begin
        mem_req_s = 1'b0;
        if ((state_s == ST_REQ) && (count_s < DEPTH_C)) begin
            mem_req_s = 1'b1;
        end else begin
            mem_req_s = 1'b0;
        end
    end

    // Control registers: FSM state, PCs, stale/halt flags and the registered memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pc_r        <= PC_ENTRY;
            req_pc_r    <= {PC_L{1'b0}};
            stale_r     <= 1'b0;
            halted_r    <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= {MADDR_L{1'b0}};
            out_valid_r <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            req_pc_r    <= req_pc_s;
            stale_r     <= stale_s;
            halted_r    <= halted_s;
            mem_req_r   <= mem_req_s;
            mem_addr_r  <= pc_s[MADDR_L-1:0];
            out_valid_r <= (count_s != {CNT_W{1'b0}});
            count_r     <= count_s;
        end
    end

    // Queue pointers. Both pointers return to zero on a flush; otherwise they wrap modulo FQ_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Queue storage. It is cleared on reset so that the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_pc_r[i]   <= {PC_L{1'b0}};
                fq_inst_r[i] <= {INST_L{1'b0}};
            end
        end else if (push_s) begin
            fq_pc_r[wr_ptr_r]   <= req_pc_r;
            fq_inst_r[wr_ptr_r] <= word_s;
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_inst  = fq_inst_r[rd_ptr_r];
    assign bus.out_pc    = fq_pc_r[rd_ptr_r];
    assign bus.halted    = halted_r;
    assign bus.fq_count  = count_r;
endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.INST_L(32), .PC_L(32), .MADDR_L(32), .FQ_DEPTH(4)) bus  ();
    if_fetch_unit_if #(.INST_L(32), .PC_L(32), .MADDR_L(32), .FQ_DEPTH(2)) bus2 ();

    if_fetch_unit #(.INST_L(32), .PC_L(32), .MADDR_L(32), .PC_ENTRY(32'h0),
                    .FQ_DEPTH(4), .BYTE_SWAP(0), .HALT_ON_ZERO(1))
        dut (.clk(clk), .rst(rst), .bus(bus));

    if_fetch_unit #(.INST_L(32), .PC_L(32), .MADDR_L(32), .PC_ENTRY(32'h0),
                    .FQ_DEPTH(2), .BYTE_SWAP(1), .HALT_ON_ZERO(0))
        dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // memory model configuration
    int          lat       = 0;
    bit          zero_en   = 1'b1;
    logic [31:0] zero_addr = 32'h0000_000C;

    bit spacing_en = 1'b0;
    bit le1_en     = 1'b0;
    int last_pop   = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents: 0x24010001, 0x24020002, ... with an optional zero word at zero_addr.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] n;
        n = a[9:2] + 8'd1;
        if (zero_en && (a == zero_addr)) return 32'h0000_0000;
        return {8'h24, n, 8'h00, n};
    endfunction

    task automatic expect_pc(input logic [31:0] pc);
        sb_q.push_back({pc, word_at(pc)});
    endtask

    // sel: 0 halted, 1 fq_count==val, 2 mem_req && fq_count==val, 3 mem_req
    task automatic wait_until(input string name, input int sel, input int val);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            case (sel)
                0: got = bus.halted;
                1: got = (bus.fq_count == 3'(val));
                2: got = bus.mem_req && (bus.fq_count == 3'(val));
                default: got = bus.mem_req;
            endcase
        end
        check(name, {63'd0, got}, 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_req"},   bus.mem_req,   0);
        check({tag, "_mem_addr"},  bus.mem_addr,  0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_inst"},  bus.out_inst,  0);
        check({tag, "_out_pc"},    bus.out_pc,    0);
        check({tag, "_halted"},    bus.halted,    0);
        check({tag, "_fq_count"},  bus.fq_count,  0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        last_pop = -1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
    endtask

    // Memory model for dut: always grants; data follows acceptance after lat extra cycles.
    bit          m_busy = 1'b0;
    bit          m_acc;
    int          m_cnt;
    logic [31:0] m_addr;
    logic [31:0] m_word;
    initial begin
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            m_acc  = bus.mem_req && bus.mem_gnt && !rst;
            m_addr = bus.mem_addr;
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
            end else begin
                if (m_acc) begin
                    m_busy = 1'b1;
                    m_cnt  = lat;
                    m_word = word_at(m_addr);
                end
                if (m_busy) begin
                    if (m_cnt == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = m_word;
                        m_busy = 1'b0;
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end
    end

    // Zero-wait memory for dut2: 0x11223344 at 0x0, zero at 0x4, filler elsewhere.
    bit          a2_acc;
    logic [31:0] a2_addr;
    initial begin
        bus2.mem_gnt    = 1'b1;
        bus2.mem_rvalid = 1'b0;
        bus2.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            a2_acc  = bus2.mem_req && !rst2;
            a2_addr = bus2.mem_addr;
            @(posedge clk); #1;
            bus2.mem_rvalid = a2_acc;
            bus2.mem_rdata  = (a2_addr == 32'h0) ? 32'h1122_3344 :
                              (a2_addr == 32'h4) ? 32'h0000_0000 : 32'h2401_0001;
        end
    end

    // Monitor: compares each accepted head entry against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && le1_en) check("fq_count_le1", {63'd0, (bus.fq_count <= 3'd1)}, 64'd1);
            if (!rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got pc 0x%0h inst 0x%0h, none expected",
                             bus.out_pc, bus.out_inst);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_pc",   bus.out_pc,   mon_e.pc);
                    check("out_inst", bus.out_inst, mon_e.inst);
                end
                if (spacing_en && last_pop >= 0) check("pop_spacing", 64'(cyc - last_pop), 64'd2);
                last_pop = cyc;
            end
        end
    end

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.out_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'h0;
        bus2.out_ready      = 1'b0;

        // Reset values, then a zero-wait stream 0x0, 0x4, 0x8 that halts on the zero at 0xC.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        spacing_en = 1'b1;
        le1_en     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t1_idle_no_req", bus.mem_req, 0);
        @(negedge clk);
        check("t1_first_req",  bus.mem_req,  1);
        check("t1_first_addr", bus.mem_addr, 32'h0);
        wait_until("t1_halt_reached", 0, 0);
        check("t1_halt_no_req", bus.mem_req, 0);
        repeat (2) @(negedge clk);
        check("t1_sb_empty", sb_q.size(), 0);
        spacing_en = 1'b0;
        le1_en     = 1'b0;

        // Zero at 0x8 with decode stalled: halt, drain 0x0/0x4, then redirect to 0x20.
        do_reset();
        bus.out_ready = 1'b0;
        zero_addr = 32'h8;
        expect_pc(32'h0); expect_pc(32'h4);
        rst = 1'b0;
        wait_until("t2_halt_reached", 0, 0);
        check("t2_count",     bus.fq_count,  2);
        check("t2_no_req",    bus.mem_req,   0);
        check("t2_out_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t2_drained",     bus.fq_count, 0);
        check("t2_still_halt",  bus.halted,   1);
        check("t2_sb_empty",    sb_q.size(),  0);
        zero_addr = 32'h28;
        expect_pc(32'h20); expect_pc(32'h24);
        pulse_redirect(32'h20);
        @(negedge clk);
        check("t2_unhalted",  bus.halted,   0);
        check("t2_req",       bus.mem_req,  1);
        check("t2_addr",      bus.mem_addr, 32'h20);
        wait_until("t2_halt2_reached", 0, 0);
        check("t2_sb_empty2", sb_q.size(), 0);

        // Backpressure: exactly FQ_DEPTH entries, requests stop, then resume at 0x10.
        do_reset();
        bus.out_ready = 1'b0;
        zero_en = 1'b0;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        rst = 1'b0;
        wait_until("t3_full", 1, 4);
        repeat (3) @(negedge clk);
        check("t3_count",     bus.fq_count,  4);
        check("t3_no_req",    bus.mem_req,   0);
        check("t3_out_valid", bus.out_valid, 1);
        check("t3_head_pc",   bus.out_pc,    32'h0);
        check("t3_next_addr", bus.mem_addr,  32'h10);
        zero_en = 1'b1;
        zero_addr = 32'h18;
        expect_pc(32'h10); expect_pc(32'h14);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_resume_req",  bus.mem_req,  1);
        check("t3_resume_addr", bus.mem_addr, 32'h10);
        wait_until("t3_halt_reached", 0, 0);
        repeat (6) @(negedge clk);
        check("t3_sb_empty", sb_q.size(), 0);

        // Slow memory: a redirect to 0x1002 during WAIT discards the late word.
        do_reset();
        bus.out_ready = 1'b1;
        lat = 3;
        zero_addr = 32'h1008;
        expect_pc(32'h1000); expect_pc(32'h1004);
        rst = 1'b0;
        wait_until("t4_req_seen", 3, 0);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1002;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_count",     bus.fq_count,  0);
        check("t4_out_valid", bus.out_valid, 0);
        check("t4_no_req",    bus.mem_req,   0);
        wait_until("t4_req_again", 3, 0);
        check("t4_addr", bus.mem_addr, 32'h1000);
        wait_until("t4_halt_reached", 0, 0);
        check("t4_sb_empty", sb_q.size(), 0);
        lat = 0;

        // Redirect coinciding with rvalid and a pop, queue holding three entries.
        do_reset();
        bus.out_ready = 1'b0;
        zero_addr = 32'h48;
        expect_pc(32'h40); expect_pc(32'h44);
        rst = 1'b0;
        wait_until("t5_three", 2, 3);
        @(posedge clk); #1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(negedge clk);
        check("t5_wait_count", bus.fq_count, 3);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_flushed",   bus.fq_count,  0);
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_req",       bus.mem_req,   1);
        check("t5_addr",      bus.mem_addr,  32'h40);
        wait_until("t5_halt_reached", 0, 0);
        check("t5_sb_empty", sb_q.size(), 0);

        // Asynchronous reset mid-WAIT with two queued entries.
        do_reset();
        bus.out_ready = 1'b0;
        lat = 3;
        zero_en = 1'b0;
        rst = 1'b0;
        wait_until("t6_two_queued", 2, 2);
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("t6_async");
        sb_q.delete();
        lat = 0;
        zero_en = 1'b1;
        zero_addr = 32'h4;
        bus.out_ready = 1'b1;
        expect_pc(32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_no_req", bus.mem_req, 0);
        @(negedge clk);
        check("t6_req",  bus.mem_req,  1);
        check("t6_addr", bus.mem_addr, 32'h0);
        wait_until("t6_halt_reached", 0, 0);
        check("t6_sb_empty", sb_q.size(), 0);

        // Second instance: BYTE_SWAP=1, HALT_ON_ZERO=0, depth 2.
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int i = 0; i < 50 && bus2.fq_count != 2'd2; i++) @(negedge clk);
        @(negedge clk);
        check("s_count",    bus2.fq_count,  2);
        check("s_swapped",  bus2.out_inst,  32'h4433_2211);
        check("s_head_pc",  bus2.out_pc,    32'h0);
        check("s_no_halt",  bus2.halted,    0);
        @(posedge clk); #1;
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
        @(negedge clk);
        check("s_zero_inst", bus2.out_inst, 32'h0);
        check("s_zero_pc",   bus2.out_pc,   32'h4);
        check("s_no_halt2",  bus2.halted,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
